fdiv_norm_round: RTL and testbench

//  Post-divide normalise/round stage of the FP divider (FDiv); sits directly downstream of the
//  32-bit leading-zero counter. Takes a raw Q1.31 quotient with its LZC result and produces an

---
 rtl/fdiv_norm_round_if.sv | 33 +++
 rtl/fdiv_norm_round.sv | 165 ++++++++++++++++
 tb/tb_fdiv_norm_round.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdiv_norm_round_if.sv
// Handshake and data bundle for the FP divider normalise/round stage.
// master = upstream/downstream environment side, slave = the stage itself.
interface fdiv_norm_round_if #(
  parameter int W   = 32,
  parameter int LZW = 5,
  parameter int EW  = 10
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         quo;
  logic [LZW-1:0]       lzc;
  logic                 all_zero;
  logic                 sticky_in;
  logic signed [EW-1:0] exp_in;
  logic                 sign_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          result;
  logic                 flag_of;
  logic                 flag_uf;
  logic                 flag_nx;

  modport master (
    output flush, in_valid, quo, lzc, all_zero, sticky_in, exp_in, sign_in, out_ready,
    input  in_ready, out_valid, result, flag_of, flag_uf, flag_nx
  );

  modport slave (
    input  flush, in_valid, quo, lzc, all_zero, sticky_in, exp_in, sign_in, out_ready,
    output in_ready, out_valid, result, flag_of, flag_uf, flag_nx
  );
endinterface

// File: rtl/fdiv_norm_round.sv
// Post-divide normalise/round stage of the FP divider.
// S1 left-justifies the Q1.31 quotient using the upstream LZC result and
// adjusts the exponent; S2 rounds to nearest-even and packs an IEEE-754
// single, flushing underflow to signed zero and saturating overflow to inf.
module fdiv_norm_round #(
  parameter int W   = 32,
  parameter int LZW = 5,
  parameter int EW  = 10
) (
  input logic               clk,
  input logic               rst,
  fdiv_norm_round_if.slave  bus
);

  // Largest biased exponent that is still finite plus one (all-ones field).
  localparam logic [EW-1:0] EXP_INF = {{(EW-8){1'b0}}, 8'hFF};

  // Pipeline slot S1: normalised mantissa and exponent
  logic                 s1_valid_r;
  logic [W-1:0]         s1_m_r;
  logic [EW-1:0]        s1_e_r;
  logic                 s1_zero_r;
  logic                 s1_sign_r;
  logic                 s1_sticky_r;

  // Pipeline slot S2: packed result and flags (drive the outputs directly)
  logic                 s2_valid_r;
  logic [31:0]          result_r;
  logic                 of_r;
  logic                 uf_r;
  logic                 nx_r;

  // Handshake
  logic                 s2_load_s;
  logic                 s1_load_s;

  // S1 datapath
  logic [W-1:0]         norm_m_s;
  logic [EW-1:0]        norm_e_s;

  // S2 datapath
  logic [23:0]          frac_s;
  logic                 guard_s;
  logic                 sticky_s;
  logic                 inc_s;
  logic [24:0]          sum_s;
  logic [23:0]          frac_rnd_s;
  logic [EW:0]          e_rnd_s;
  logic                 ovf_s;
  logic                 unf_s;
  logic [31:0]          res_s;
  logic                 of_s;
  logic                 uf_s;
  logic                 nx_s;

  // A slot advances when it is empty or its consumer takes its contents.
  assign s2_load_s    = !s2_valid_r | bus.out_ready;
  assign s1_load_s    = !s1_valid_r | s2_load_s;
  assign bus.in_ready = s1_load_s;

  assign bus.out_valid = s2_valid_r;
  assign bus.result    = result_r;
  assign bus.flag_of   = of_r;
  assign bus.flag_uf   = uf_r;
  assign bus.flag_nx   = nx_r;

  // Normalise: shift out the leading zeros and debit them from the exponent.
  always_comb begin
    norm_m_s = bus.quo << bus.lzc;
    norm_e_s = bus.exp_in - {{(EW-LZW){1'b0}}, bus.lzc};
  end

  // S1 slot register; flush wins over a simultaneous input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_m_r      <= {W{1'b0}};
      s1_e_r      <= {EW{1'b0}};
      s1_zero_r   <= 1'b0;
      s1_sign_r   <= 1'b0;
      s1_sticky_r <= 1'b0;
    end else if (bus.flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_m_r      <= norm_m_s;
        s1_e_r      <= norm_e_s;
        s1_zero_r   <= bus.all_zero;
        s1_sign_r   <= bus.sign_in;
        s1_sticky_r <= bus.sticky_in;
      end
    end
  end

  // Round to nearest-even, then pick the packed result by special-case priority.
  always_comb begin
    frac_s     = s1_m_r[W-1 -: 24];
    guard_s    = s1_m_r[W-25];
    sticky_s   = (|s1_m_r[W-26:0]) | s1_sticky_r;
    inc_s      = guard_s & (sticky_s | frac_s[0]);
    sum_s      = {1'b0, frac_s} + {24'd0, inc_s};
    e_rnd_s    = {s1_e_r[EW-1], s1_e_r};
    frac_rnd_s = sum_s[23:0];
    if (sum_s[24]) begin
      // Rounding overflowed the mantissa: renormalise to 1.0 and bump exponent.
      frac_rnd_s = 24'h80_0000;
      e_rnd_s    = e_rnd_s + {{EW{1'b0}}, 1'b1};
    end else begin
      frac_rnd_s = sum_s[23:0];
    end
    ovf_s = !e_rnd_s[EW] & (e_rnd_s[EW-1:0] >= EXP_INF);
    unf_s = e_rnd_s[EW] | (e_rnd_s == {(EW+1){1'b0}});

    res_s = {s1_sign_r, e_rnd_s[7:0], frac_rnd_s[22:0]};
    of_s  = 1'b0;
    uf_s  = 1'b0;
    nx_s  = guard_s | sticky_s;
    if (s1_zero_r & !s1_sticky_r) begin
      res_s = {s1_sign_r, 31'd0};
      nx_s  = 1'b0;
    end else if (ovf_s) begin
      res_s = {s1_sign_r, 8'hFF, 23'd0};
      of_s  = 1'b1;
      nx_s  = 1'b1;
    end else if (unf_s) begin
      res_s = {s1_sign_r, 31'd0};
      uf_s  = 1'b1;
      nx_s  = 1'b1;
    end else begin
      res_s = {s1_sign_r, e_rnd_s[7:0], frac_rnd_s[22:0]};
    end
  end

  // S2 slot register; flags and result are zeroed whenever the slot is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      result_r   <= 32'd0;
      of_r       <= 1'b0;
      uf_r       <= 1'b0;
      nx_r       <= 1'b0;
    end else if (bus.flush) begin
      s2_valid_r <= 1'b0;
      result_r   <= 32'd0;
      of_r       <= 1'b0;
      uf_r       <= 1'b0;
      nx_r       <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= res_s;
        of_r     <= of_s;
        uf_r     <= uf_s;
        nx_r     <= nx_s;
      end else begin
        result_r <= 32'd0;
        of_r     <= 1'b0;
        uf_r     <= 1'b0;
        nx_r     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fdiv_norm_round.sv
// Self-checking bench for fdiv_norm_round: directed spot checks plus random
// traffic with backpressure, scored against an arithmetic rounding model.
module tb_fdiv_norm_round;
  localparam int W   = 32;
  localparam int LZW = 5;
  localparam int EW  = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fdiv_norm_round_if #(.W(W), .LZW(LZW), .EW(EW)) bus ();

  fdiv_norm_round #(.W(W), .LZW(LZW), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {result, of, uf, nx} per accepted op, oldest first.
  logic [34:0] exp_q[$];

  // Values captured at the falling edge before each rising edge.
  logic        c_in_fire, c_out_fire, c_out_valid, c_in_ready;
  logic [34:0] c_out;

  // Currently driven op.
  logic [31:0] op_quo;
  logic [4:0]  op_lzc;
  logic        op_az, op_st, op_sg;
  int          op_e;

  function automatic logic [4:0] lzc_of(logic [31:0] q);
    for (int i = 31; i >= 0; i--) begin
      if (q[i]) return 5'(31 - i);
    end
    return 5'd0;
  endfunction

  // Reference: value-level rounding by comparing the discarded tail with one half ulp.
  function automatic logic [34:0] model(logic [31:0] quo, logic [4:0] lzc, logic az,
                                        logic st, int e_in, logic sg);
    longint m, keep, rem;
    int     e;
    logic   nx;
    if (az && !st) return {sg, 31'd0, 3'b000};
    m    = (longint'(quo) << lzc) & 64'h0000_0000_FFFF_FFFF;
    e    = e_in - int'(lzc);
    keep = m / 256;
    rem  = m % 256;
    nx   = (rem != 0) || st;
    if (rem > 128 || (rem == 128 && (st || (keep % 2 == 1)))) keep = keep + 1;
    if (keep == 64'd16777216) begin
      keep = 64'd8388608;
      e    = e + 1;
    end
    if (e >= 255) return {sg, 8'hFF, 23'd0, 3'b101};
    if (e <= 0)   return {sg, 31'd0, 3'b011};
    return {sg, e[7:0], keep[22:0], 2'b00, nx};
  endfunction

  task automatic drive_op(logic [31:0] q, logic st, int e, logic sg);
    op_quo = q;
    op_az  = (q == 32'd0);
    op_lzc = lzc_of(q);
    op_st  = st;
    op_e   = e;
    op_sg  = sg;
    bus.quo       = q;
    bus.lzc       = op_lzc;
    bus.all_zero  = op_az;
    bus.sticky_in = st;
    bus.exp_in    = e[EW-1:0];
    bus.sign_in   = sg;
    bus.in_valid  = 1'b1;
  endtask

  task automatic gen_op();
    logic [31:0] q;
    int          sh;
    q  = $urandom();
    sh = $urandom_range(0, 31);
    q  = q >> sh;
    if ($urandom_range(0, 7) == 0) q[7:0] = 8'h80;
    if ($urandom_range(0, 15) == 0) q = 32'd0;
    drive_op(q, 1'($urandom_range(0, 1)), int'($urandom_range(0, 330)) - 30,
             1'($urandom_range(0, 1)));
  endtask

  // Sample at the falling edge, then advance past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    c_in_ready  = bus.in_ready;
    c_out_valid = bus.out_valid;
    c_in_fire   = bus.in_valid & bus.in_ready & !rst;
    c_out_fire  = bus.out_valid & bus.out_ready & !rst;
    c_out       = {bus.result, bus.flag_of, bus.flag_uf, bus.flag_nx};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gen_op();
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    n_cmp++;
    if (c_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", c_out_valid); end
    n_cmp++;
    if (c_out !== 35'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", c_out); end
    n_cmp++;
    if (c_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", c_in_ready); end
    cycle();
    n_cmp++;
    if (c_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ghost: got %b want 0", c_out_valid); end
  endtask

  task automatic test_directed();
    logic [31:0] d_quo[8] = '{32'h8000_0000, 32'h4000_0000, 32'hFFFF_FF80, 32'h8000_0080,
                             32'h8000_0080, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    logic        d_st[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int          d_e[8]   = '{127, 128, 127, 127, 127, 255, 0, 127};
    logic        d_sg[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [34:0] d_exp[8] = '{{32'h3F80_0000, 3'b000}, {32'h3F80_0000, 3'b000},
                             {32'h4000_0000, 3'b001}, {32'h3F80_0000, 3'b001},
                             {32'h3F80_0001, 3'b001}, {32'h7F80_0000, 3'b101},
                             {32'h8000_0000, 3'b011}, {32'h0000_0000, 3'b000}};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_op(d_quo[i], d_st[i], d_e[i], d_sg[i]);
      cycle();
      n_cmp++;
      if (c_in_fire !== 1'b1) begin n_bad++; $display("FAIL dir%0d_accept: got %b want 1", i, c_in_fire); end
      bus.in_valid = 1'b0;
      cycle();
      n_cmp++;
      if (c_out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_early: got %b want 0", i, c_out_valid); end
      cycle();
      n_cmp++;
      if (c_out_valid !== 1'b1 || c_out !== d_exp[i]) begin
        n_bad++;
        $display("FAIL dir%0d_result: got v=%b %h want v=1 %h", i, c_out_valid, c_out, d_exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0, outs = 0, first = -1, last = -1;
    bus.out_ready = 1'b0;
    gen_op();
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (c_in_fire) begin
        exp_q.push_back(model(op_quo, op_lzc, op_az, op_st, op_e, op_sg));
        acc++;
        gen_op();
      end
    end
    n_cmp++;
    if (acc !== 2) begin n_bad++; $display("FAIL bp_accepts: got %0d want 2", acc); end
    n_cmp++;
    if (c_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", c_in_ready); end
    n_cmp++;
    if (c_out_valid !== 1'b1 || exp_q.size() == 0 || c_out !== exp_q[0]) begin
      n_bad++;
      $display("FAIL bp_held: got v=%b %h want v=1 head of queue", c_out_valid, c_out);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8 && outs < 3; i++) begin
      cycle();
      if (c_out_fire) begin
        n_cmp++;
        if (exp_q.size() == 0 || c_out !== exp_q[0]) begin
          n_bad++;
          $display("FAIL bp_order%0d: got %h want %h", outs, c_out, (exp_q.size() != 0) ? exp_q[0] : 35'd0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (first < 0) first = i;
        last = i;
        outs++;
      end
      if (c_in_fire && acc < 3) begin
        exp_q.push_back(model(op_quo, op_lzc, op_az, op_st, op_e, op_sg));
        acc++;
        if (acc == 3) bus.in_valid = 1'b0;
        else gen_op();
      end
    end
    n_cmp++;
    if (outs !== 3 || last - first !== 2) begin
      n_bad++;
      $display("FAIL bp_drain: got %0d outs over span %0d want 3 over 2", outs, last - first);
    end
    exp_q.delete();
  endtask

  task automatic test_abort(input bit use_rst);
    int acc = 0;
    bus.out_ready = 1'b0;
    gen_op();
    for (int i = 0; i < 6 && acc < 2; i++) begin
      cycle();
      if (c_in_fire) begin acc++; gen_op(); end
    end
    n_cmp++;
    if (acc !== 2) begin n_bad++; $display("FAIL abort%0d_fill: got %0d want 2", use_rst, acc); end
    bus.out_ready = 1'b1;
    if (use_rst) rst = 1'b1;
    else bus.flush = 1'b1;
    cycle();
    if (!use_rst) begin
      n_cmp++;
      if (c_in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", c_in_ready); end
    end
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (c_out_valid !== 1'b0 || c_out[2:0] !== 3'b000) begin
        n_bad++;
        $display("FAIL abort%0d_drop%0d: got v=%b flags=%b want v=0 flags=000", use_rst, i, c_out_valid, c_out[2:0]);
      end
      if (use_rst) begin
        n_cmp++;
        if (c_out !== 35'd0) begin n_bad++; $display("FAIL rst_zero%0d: got %h want 0", i, c_out); end
      end
    end
    drive_op(32'h8000_0000, 1'b0, 127, 1'b0);
    cycle();
    n_cmp++;
    if (c_in_fire !== 1'b1) begin n_bad++; $display("FAIL abort%0d_accept: got %b want 1", use_rst, c_in_fire); end
    bus.in_valid = 1'b0;
    cycle();
    n_cmp++;
    if (c_out_valid !== 1'b0) begin n_bad++; $display("FAIL abort%0d_early: got %b want 0", use_rst, c_out_valid); end
    cycle();
    n_cmp++;
    if (c_out_valid !== 1'b1 || c_out !== {32'h3F80_0000, 3'b000}) begin
      n_bad++;
      $display("FAIL abort%0d_next: got v=%b %h want v=1 3f8000000", use_rst, c_out_valid, c_out);
    end
  endtask

  task automatic test_random();
    bit fired = 1'b1;
    exp_q.delete();
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!bus.in_valid || fired) begin
        if ($urandom_range(0, 9) < 7) gen_op();
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      fired = c_in_fire;
      if (c_out_fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rnd_extra: got %h want no output", c_out);
        end else begin
          if (c_out !== exp_q[0]) begin
            n_bad++;
            $display("FAIL rnd_result: got %h want %h", c_out, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (!c_out_valid) begin
        n_cmp++;
        if (c_out[2:0] !== 3'b000) begin n_bad++; $display("FAIL rnd_idle_flags: got %b want 000", c_out[2:0]); end
      end
      if (c_in_fire) exp_q.push_back(model(op_quo, op_lzc, op_az, op_st, op_e, op_sg));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      cycle();
      if (c_out_fire) begin
        n_cmp++;
        if (c_out !== exp_q[0]) begin n_bad++; $display("FAIL rnd_drain: got %h want %h", c_out, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_bad++; $display("FAIL rnd_lost: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.quo       = 32'd0;
    bus.lzc       = 5'd0;
    bus.all_zero  = 1'b0;
    bus.sticky_in = 1'b0;
    bus.exp_in    = 10'd0;
    bus.sign_in   = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
